// File: rtl/mult_bank_sched.sv
// Operand sequencer in front of the multiply vector bank.
// Arbitrates two requesters (round robin on conflict), writes the winner's
// A vector to bank position 0 and B vector to position 1 on consecutive
// cycles, waits SETTLE_CYC cycles, pulses mul_start, holds until mul_done
// and then reports the owner of the finished operation for one cycle.
module mult_bank_sched #(
  parameter int LANES      = 4,
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  input  logic [LANES*DATA_W-1:0]   req0_a,
  input  logic [LANES*DATA_W-1:0]   req0_b,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [LANES*DATA_W-1:0]   req1_a,
  input  logic [LANES*DATA_W-1:0]   req1_b,
  output logic                      req1_ready,
  output logic                      bank_we,
  output logic                      bank_wr_pos,
  output logic [DATA_W-1:0]         bank_wd1,
  output logic [DATA_W-1:0]         bank_wd2,
  output logic [DATA_W-1:0]         bank_wd3,
  output logic [DATA_W-1:0]         bank_wd4,
  output logic                      mul_start,
  input  logic                      mul_done,
  output logic                      busy,
  output logic                      done_valid,
  output logic                      done_id,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_A   = 3'd1,
    WR_B   = 3'd2,
    SETTLE = 3'd3,
    EXEC   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int VEC_W = LANES * DATA_W;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  state_t             state;
  state_t             state_nx;
  logic [VEC_W-1:0]   a_q;
  logic [VEC_W-1:0]   b_q;
  logic [VEC_W-1:0]   wvec;
  logic               gnt_id;
  logic               rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               start_q;
  logic               grant;

  // Handshake: a transfer happens on a rising edge where reqN_valid and
  // reqN_ready are both high. Ready is only offered in IDLE, never to both
  // requesters at once, and may depend combinationally on the valids.
  // Ties go to the requester rr_ptr points at. Held low while rst is high.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && (!req1_valid || !rr_ptr)) req0_ready = 1'b1;
      else if (req1_valid)                        req1_ready = 1'b1;
    end
  end

  assign grant = req0_ready | req1_ready;

  // Next-state logic; mul_done only matters while in EXEC.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = WR_A;
      WR_A:    state_nx = WR_B;
      WR_B:    state_nx = (SETTLE_CYC == 0) ? EXEC : SETTLE;
      SETTLE:  if (cnt == CNT_LAST) state_nx = EXEC;
      EXEC:    if (mul_done) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, operand capture, round-robin pointer, settle counter, start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gnt_id  <= 1'b0;
      rr_ptr  <= 1'b0;
      cnt     <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      // Registered so the pulse has no path from mul_done; asserted only on
      // the first EXEC cycle.
      start_q <= (state_nx == EXEC) && (state != EXEC);
      cnt     <= (state == SETTLE) ? cnt + 1'b1 : '0;
      if (grant) begin
        a_q    <= req1_ready ? req1_a : req0_a;
        b_q    <= req1_ready ? req1_b : req0_b;
        gnt_id <= req1_ready;
        rr_ptr <= ~req1_ready;
      end
    end
  end

  // Bank write port: pure decode of state over the captured operands.
  always_comb begin
    bank_we     = 1'b0;
    bank_wr_pos = 1'b0;
    wvec        = '0;
    case (state)
      WR_A: begin
        bank_we = 1'b1;
        wvec    = a_q;
      end
      WR_B: begin
        bank_we     = 1'b1;
        bank_wr_pos = 1'b1;
        wvec        = b_q;
      end
      default: ;
    endcase
  end

  assign bank_wd1   = wvec[0*DATA_W +: DATA_W];
  assign bank_wd2   = wvec[1*DATA_W +: DATA_W];
  assign bank_wd3   = wvec[2*DATA_W +: DATA_W];
  assign bank_wd4   = wvec[3*DATA_W +: DATA_W];
  assign mul_start  = start_q;
  assign busy       = (state != IDLE);
  assign done_valid = (state == DONE);
  assign done_id    = (state == DONE) & gnt_id;
  assign state_dbg  = state;

endmodule
